telemetry_tx: RTL and testbench
===============================

// Module: telemetry_tx
// PURPOSE
//  Drives the TX pin of the eBike: periodically snapshots batt, curr, torque (12-bit A2D results)
//  and sends them as a framed byte packet over UART 8N1 at 115200 baud (50MHz clk).
//  Sits between the A2D_intf/sensorCondition outputs and the TX pad; consumer is the host logger.
// PARAMETERS
//  FAST_SIM  1    1: packet period 2^16 clks; 0: packet period 2^22 clks (~84ms)
//  BAUD_DIV  434  clks per UART bit (50MHz/115200)
// PORTS
//  clk     in   1   50MHz system clock
//  rst_n   in   1   asynchronous active-low reset (from reset_synch)
//  en      in   1   1: period counter runs; 0: counter holds, in-flight packet completes
//  batt    in   12  battery voltage reading
//  curr    in   12  motor current reading
//  torque  in   12  pedal torque reading
//  TX      out  1   UART serial out, idle high
//  busy    out  1   high from first start bit through last stop bit of a packet
//  drop    out  1   1-clk pulse when period expires while busy (packet skipped)
// BEHAVIOUR
//  Reset: TX=1, busy=0, drop=0, period counter=0, state IDLE, byte index=0.
//  Period counter: free-running when en=1; trigger on the wrap cycle (all ones -> 0).
//  Trigger while IDLE: batt/curr/torque captured into shadow regs that same edge; busy=1 next clk;
//   start bit of byte 0 drives TX on the clk after the trigger (latency 1).
//  Trigger while busy: ignored, drop pulses 1 clk, counter keeps running (no pending queue).
//  Packet bytes, in order: 0xAA, 0x55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0],
//   {4'h0,torque[11:8]}, torque[7:0]. Inputs changing mid-packet have no effect (shadow regs).
//  Byte frame: start(0), d0..d7 LSB first, stop(1); each bit exactly BAUD_DIV clks.
//  Byte n+1 start bit immediately follows byte n stop bit (no idle gap). Frame = 10*BAUD_DIV clks.
//  busy falls the clk after the last stop bit completes; TX stays 1 while IDLE.
//  FSM: IDLE -> (trigger) LOAD -> SEND (uart_tx active) -> NEXT (index++; last byte ? IDLE : LOAD).
//   LOAD/NEXT are 0-time decode states folded into the baud counter boundary; no extra clk gaps.
//  en deasserted mid-packet: packet finishes normally; counter frozen at current value.
//  rst_n asserted mid-packet: TX forced to 1 immediately (async), packet abandoned, no partial resume.
//  Baud counter: counts 0..BAUD_DIV-1; bit sample boundary at BAUD_DIV-1; bit counter 0..9.
// CONFIGURATION
//  `TELEM_CHKSUM_EN defined: a 9th byte is appended = ~(sum of bytes 2..7)[7:0] (8-bit wrap of sum);
//   packet = 9 frames. Undefined: packet ends after byte 7 (8 frames); no checksum logic present.
//  Both variants fit within the FAST_SIM period (9*4340=39060 < 65536).
// STRUCTURE
//  Package telem_pkg: SYNC0=8'hAA, SYNC1=8'h55, NUM_BYTES (8 or 9 per macro), state enum
//   typedef (IDLE/LOAD/SEND/NEXT), period width function of FAST_SIM.
//  Sub-module uart_tx (clk, rst_n, trmt, tx_data[7:0], TX, tx_done): one 8N1 frame per trmt pulse;
//   telemetry_tx owns period counter, shadow regs, byte mux, packet FSM, checksum accumulator.
// TESTING
//  1. batt=12'hABC, curr=12'h123, torque=12'h7FF, en=1 -> decoded bytes AA 55 0A BC 01 23 07 FF;
//     with TELEM_CHKSUM_EN 9th byte 0x0F.
//  2. Measure bit time: every TX edge spaced by multiple of 434 clks; start bit of byte 0 one clk
//     after trigger; byte-to-byte gap 0 clks; busy high for exactly 8*4340 (9*4340) clks.
//  3. Change batt to 12'h000 mid-packet (after byte 2) -> packet still carries 0A BC; next packet 00 00.
//  4. Force trigger while busy (BAUD_DIV overridden to 20000 so packet > period) -> drop pulses 1 clk,
//     no second packet starts until busy falls and next wrap occurs.
//  5. Assert rst_n low during byte 4 -> TX=1, busy=0 same cycle; after release no TX activity
//     until first period wrap (65536 clks with FAST_SIM=1).
//  6. en=0 from reset -> TX stays 1 for 200000 clks; en=1 -> first packet starts 65536 clks later.

Source files
------------

// File: rtl/telem_pkg.sv
// rtl/telem_pkg.sv - shared constants, state type and period sizing for telemetry_tx
// TELEM_CHKSUM_EN selects the 9-byte packet with a trailing checksum byte.
package telem_pkg;

   localparam logic [7:0] SYNC0 = 8'hAA;
   localparam logic [7:0] SYNC1 = 8'h55;

`ifdef TELEM_CHKSUM_EN
   localparam int NUM_BYTES = 9;
`else
   localparam int NUM_BYTES = 8;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      NEXT = 2'd3
   } state_t;

   function automatic int period_width(input int fast_sim);
      return (fast_sim != 0) ? 16 : 22;
   endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter, one frame per trmt pulse
// tx_done is combinational on the last stop-bit clk so the next frame can start with no gap.
module uart_tx #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       TX,
   output logic       tx_done
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [8:0]    shift;
   logic          active;
   logic          bit_end;

   assign bit_end = active && (baud_cnt == BW'(BAUD_DIV - 1));
   assign tx_done = bit_end && (bit_cnt == 4'd9);

   // shift carries {stop, data}; ones fill in behind so the stop bit falls out naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         TX       <= 1'b1;
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '1;
      end else if (trmt) begin
         TX       <= 1'b0;
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= {1'b1, tx_data};
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
               active <= 1'b0;
               TX     <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
               TX      <= shift[0];
               shift   <= {1'b1, shift[8:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/telemetry_tx.sv
// rtl/telemetry_tx.sv - periodic batt/curr/torque telemetry packets over UART 8N1
// TELEM_CHKSUM_EN appends ~(sum of bytes 2..7) as a 9th byte.
module telemetry_tx
   import telem_pkg::*;
#(
   parameter int FAST_SIM = 1,
   parameter int BAUD_DIV = 434,
   parameter int PERIOD_W = period_width(FAST_SIM)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] batt,
   input  logic [11:0] curr,
   input  logic [11:0] torque,
   output logic        TX,
   output logic        busy,
   output logic        drop
);

   logic [PERIOD_W-1:0] period_cnt;
   state_t              state;
   logic [3:0]          idx;
   logic [3:0]          send_idx;
   logic [11:0]         batt_s;
   logic [11:0]         curr_s;
   logic [11:0]         torque_s;
   logic                trigger;
   logic                trmt;
   logic                tx_done;
   logic                last_byte;
   logic [7:0]          tx_data;

   assign trigger   = en && (&period_cnt);
   assign last_byte = (idx == 4'(NUM_BYTES - 1));

   // Next byte is issued on the same clk the previous stop bit ends
   always_comb begin
      trmt     = 1'b0;
      send_idx = idx;
      if (state == IDLE) begin
         trmt     = trigger;
         send_idx = 4'd0;
      end else if (tx_done && !last_byte) begin
         trmt     = 1'b1;
         send_idx = idx + 4'd1;
      end
   end

`ifdef TELEM_CHKSUM_EN
   logic [7:0] chk_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         chk_sum <= '0;
      else if (state == IDLE)
         chk_sum <= '0;
      else if (trmt && (send_idx >= 4'd2) && (send_idx <= 4'd7))
         chk_sum <= chk_sum + tx_data;
   end
`endif

   // Byte 0 is constant, so the trigger clk can use it before the shadows load
   always_comb begin
      tx_data = 8'hFF;
      case (send_idx)
         4'd0: tx_data = SYNC0;
         4'd1: tx_data = SYNC1;
         4'd2: tx_data = {4'h0, batt_s[11:8]};
         4'd3: tx_data = batt_s[7:0];
         4'd4: tx_data = {4'h0, curr_s[11:8]};
         4'd5: tx_data = curr_s[7:0];
         4'd6: tx_data = {4'h0, torque_s[11:8]};
         4'd7: tx_data = torque_s[7:0];
`ifdef TELEM_CHKSUM_EN
         4'd8: tx_data = ~chk_sum;
`endif
         default: tx_data = 8'hFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
         state      <= IDLE;
         idx        <= '0;
         busy       <= 1'b0;
         drop       <= 1'b0;
         batt_s     <= '0;
         curr_s     <= '0;
         torque_s   <= '0;
      end else begin
         if (en)
            period_cnt <= period_cnt + 1'b1;
         drop <= trigger && (state != IDLE);
         case (state)
            IDLE: begin
               if (trigger) begin
                  state    <= SEND;
                  busy     <= 1'b1;
                  idx      <= '0;
                  batt_s   <= batt;
                  curr_s   <= curr;
                  torque_s <= torque;
               end
            end
            default: begin
               if (tx_done) begin
                  if (last_byte) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   uart_tx #(
      .BAUD_DIV(BAUD_DIV)
   ) u_uart_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .trmt   (trmt),
      .tx_data(tx_data),
      .TX     (TX),
      .tx_done(tx_done)
   );

endmodule

// File: tb/tb_telemetry_tx.sv
// tb/tb_telemetry_tx.sv - self-checking bench for telemetry_tx (shortened period and bit time)
// dut_a carries packets shorter than the period; dut_b has packets longer than the period.
module tb_telemetry_tx;

   localparam int PW  = 10;
   localparam int PER = 1 << PW;
   localparam int BDA = 8;
   localparam int BDB = 20;
`ifdef TELEM_CHKSUM_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif

   logic        clk = 1'b0;
   logic        rst_n_a, en_a, rst_n_b, en_b;
   logic [11:0] batt, curr, torque;
   logic        tx_a, busy_a, drop_a;
   logic        tx_b, busy_b, drop_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int pkt_c0 = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   telemetry_tx #(.FAST_SIM(1), .BAUD_DIV(BDA), .PERIOD_W(PW)) dut_a (
      .clk(clk), .rst_n(rst_n_a), .en(en_a), .batt(batt), .curr(curr), .torque(torque),
      .TX(tx_a), .busy(busy_a), .drop(drop_a)
   );

   telemetry_tx #(.FAST_SIM(1), .BAUD_DIV(BDB), .PERIOD_W(PW)) dut_b (
      .clk(clk), .rst_n(rst_n_b), .en(en_b), .batt(batt), .curr(curr), .torque(torque),
      .TX(tx_b), .busy(busy_b), .drop(drop_b)
   );

   task automatic push_packet(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
      logic [7:0] pk[8];
      logic [7:0] s;
      pk = '{8'hAA, 8'h55, {4'h0, b[11:8]}, b[7:0], {4'h0, c[11:8]}, c[7:0],
             {4'h0, t[11:8]}, t[7:0]};
      s = 8'h00;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(pk[i]);
         if (i >= 2) s = s + pk[i];
      end
`ifdef TELEM_CHKSUM_EN
      exp_q.push_back(~s);
`endif
   endtask

   // Returns at the middle of the stop bit; t0 is the first sampled clk of the start bit
   task automatic recv_byte(output logic [7:0] b, output int t0, output bit ok);
      int n;
      bit start_ok;
      b = '0; t0 = -1; ok = 1'b0; n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_a !== 1'b0 && n < 3 * PER);
      if (tx_a !== 1'b0) return;
      t0 = cyc;
      repeat (BDA / 2) @(negedge clk);
      start_ok = (tx_a === 1'b0);
      for (int i = 0; i < 8; i++) begin
         repeat (BDA) @(negedge clk);
         b[i] = tx_a;
      end
      repeat (BDA) @(negedge clk);
      ok = start_ok && (tx_a === 1'b1);
   endtask

   task automatic test_reset;
      rst_n_a = 1'b0; rst_n_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
      batt = 12'h000; curr = 12'h000; torque = 12'h000;
      repeat (3) @(negedge clk);
      total++; if (tx_a !== 1'b1)   begin bad++; $display("FAIL reset_tx_a got=%b want=1", tx_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
      total++; if (drop_a !== 1'b0) begin bad++; $display("FAIL reset_drop_a got=%b want=0", drop_a); end
      total++; if (tx_b !== 1'b1)   begin bad++; $display("FAIL reset_tx_b got=%b want=1", tx_b); end
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL reset_busy_b got=%b want=0", busy_b); end
      total++; if (drop_b !== 1'b0) begin bad++; $display("FAIL reset_drop_b got=%b want=0", drop_b); end
   endtask

   task automatic test_packet;
      logic [7:0] b, e;
      int t0, tprev, tfirst, n;
      bit ok;
      batt = 12'hABC; curr = 12'h123; torque = 12'h7FF; en_a = 1'b1;
      @(negedge clk); rst_n_a = 1'b0;
      @(negedge clk); rst_n_a = 1'b1; pkt_c0 = cyc;
      push_packet(12'hABC, 12'h123, 12'h7FF);
      tprev = 0; tfirst = 0;
      for (int i = 0; i < NB; i++) begin
         recv_byte(b, t0, ok);
         e = exp_q.pop_front();
         total++;
         if (!ok || b !== e) begin
            bad++; $display("FAIL pkt1_byte%0d got=%h framing_ok=%0d want=%h", i, b, ok, e);
         end
         total++;
         if (i == 0) begin
            tfirst = t0;
            if (t0 != pkt_c0 + PER) begin
               bad++; $display("FAIL pkt1_start_latency got=%0d want=%0d", t0 - pkt_c0, PER);
            end
         end else if (t0 - tprev != 10 * BDA) begin
            bad++; $display("FAIL pkt1_gap%0d got=%0d want=%0d", i, t0 - tprev, 10 * BDA);
         end
         if (i == 0) begin
            total++;
            if (busy_a !== 1'b1) begin bad++; $display("FAIL pkt1_busy_high got=%b want=1", busy_a); end
         end
         if (i == 2) batt = 12'h000;
         tprev = t0;
      end
      n = 0;
      while (busy_a !== 1'b0 && n < 20 * BDA) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (cyc - tfirst != NB * 10 * BDA) begin
         bad++; $display("FAIL pkt1_busy_width got=%0d want=%0d", cyc - tfirst, NB * 10 * BDA);
      end
      total++;
      if (tx_a !== 1'b1) begin bad++; $display("FAIL pkt1_idle_tx got=%b want=1", tx_a); end
   endtask

   task automatic test_shadow;
      logic [7:0] b, e;
      int t0;
      bit ok;
      push_packet(12'h000, 12'h123, 12'h7FF);
      for (int i = 0; i < NB; i++) begin
         recv_byte(b, t0, ok);
         e = exp_q.pop_front();
         total++;
         if (!ok || b !== e) begin
            bad++; $display("FAIL pkt2_byte%0d got=%h framing_ok=%0d want=%h", i, b, ok, e);
         end
         if (i == 0) begin
            total++;
            if (t0 != pkt_c0 + 2 * PER) begin
               bad++; $display("FAIL pkt2_start got=%0d want=%0d", t0 - pkt_c0, 2 * PER);
            end
         end
      end
   endtask

   task automatic test_drop;
      int rise[$];
      int c, fall_t, drop_n, drop_t, tx_t, r0, r1;
      logic pb;
      en_b = 1'b1;
      @(negedge clk); rst_n_b = 1'b1; c = cyc;
      pb = 1'b0; fall_t = -1; drop_n = 0; drop_t = -1; tx_t = -1;
      for (int n = 0; n < 3200; n++) begin
         @(negedge clk);
         if (busy_b === 1'b1 && pb === 1'b0) rise.push_back(cyc);
         if (busy_b === 1'b0 && pb === 1'b1 && fall_t < 0) fall_t = cyc;
         if (drop_b === 1'b1) begin
            drop_n++;
            if (drop_t < 0) drop_t = cyc;
         end
         if (fall_t >= 0 && tx_t < 0 && tx_b === 1'b0) tx_t = cyc;
         pb = busy_b;
      end
      r0 = (rise.size() > 0) ? rise[0] - c : -1;
      r1 = (rise.size() > 1) ? rise[1] - c : -1;
      total++; if (r0 != PER) begin bad++; $display("FAIL drop_first_busy got=%0d want=%0d", r0, PER); end
      total++; if (drop_n != 1) begin bad++; $display("FAIL drop_pulse_len got=%0d want=1", drop_n); end
      total++; if (drop_t - c != 2 * PER) begin bad++; $display("FAIL drop_when got=%0d want=%0d", drop_t - c, 2 * PER); end
      total++;
      if (fall_t - c != PER + NB * 10 * BDB) begin
         bad++; $display("FAIL drop_busy_fall got=%0d want=%0d", fall_t - c, PER + NB * 10 * BDB);
      end
      total++; if (r1 != 3 * PER) begin bad++; $display("FAIL drop_second_busy got=%0d want=%0d", r1, 3 * PER); end
      total++; if (tx_t - c != 3 * PER) begin bad++; $display("FAIL drop_next_start got=%0d want=%0d", tx_t - c, 3 * PER); end
      rst_n_b = 1'b0; en_b = 1'b0;
   endtask

   task automatic test_reset_mid;
      int c0, c1, t0, n;
      batt = 12'hABC; curr = 12'h123; torque = 12'h7FF; en_a = 1'b1;
      @(negedge clk); rst_n_a = 1'b0;
      @(negedge clk); rst_n_a = 1'b1; c0 = cyc;
      n = 0; t0 = -1;
      while (n < 2 * PER && t0 < 0) begin
         @(negedge clk);
         n++;
         if (tx_a === 1'b0) t0 = cyc;
      end
      total++; if (t0 - c0 != PER) begin bad++; $display("FAIL rmid_start got=%0d want=%0d", t0 - c0, PER); end
      // middle of d1 of byte 4 (0x01), which is a low bit
      repeat (42 * BDA + BDA / 2) @(negedge clk);
      total++; if (tx_a !== 1'b0) begin bad++; $display("FAIL rmid_pre_tx got=%b want=0", tx_a); end
      #2 rst_n_a = 1'b0;
      #1;
      total++; if (tx_a !== 1'b1)   begin bad++; $display("FAIL rmid_async_tx got=%b want=1", tx_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_async_busy got=%b want=0", busy_a); end
      repeat (3) @(negedge clk);
      rst_n_a = 1'b1; c1 = cyc;
      n = 0; t0 = -1;
      while (n < 2 * PER && t0 < 0) begin
         @(negedge clk);
         n++;
         if (tx_a !== 1'b1 || busy_a !== 1'b0) t0 = cyc;
      end
      total++; if (t0 - c1 != PER) begin bad++; $display("FAIL rmid_restart got=%0d want=%0d", t0 - c1, PER); end
   endtask

   task automatic test_en_hold;
      int c3, t0, n, act;
      en_a = 1'b0;
      @(negedge clk); rst_n_a = 1'b0;
      @(negedge clk); rst_n_a = 1'b1;
      act = 0;
      for (int i = 0; i < 3 * PER; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || drop_a !== 1'b0) act++;
      end
      total++; if (act != 0) begin bad++; $display("FAIL en_hold_quiet got=%0d want=0", act); end
      en_a = 1'b1; c3 = cyc;
      n = 0; t0 = -1;
      while (n < 2 * PER && t0 < 0) begin
         @(negedge clk);
         n++;
         if (tx_a === 1'b0) t0 = cyc;
      end
      total++; if (t0 - c3 != PER) begin bad++; $display("FAIL en_first_start got=%0d want=%0d", t0 - c3, PER); end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_shadow();
      test_drop();
      test_reset_mid();
      test_en_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
